// File: rtl/pixel_map_pkg.sv
// ============================================================================
// Module      : pixel_map_pkg
// Description : Shared mode-bit indices, reset mode and clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_map_pkg;

  localparam int MODE_VFLIP = 0;
  localparam int MODE_HFLIP = 1;
  localparam int MODE_ZOOM  = 2;

  localparam logic [2:0] MODE_RESET = 3'b001;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_map_sync_fifo.sv
// ============================================================================
// Module      : pixel_map_sync_fifo
// Description : Show-ahead synchronous FIFO; head reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_map_sync_fifo
  import pixel_map_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic                    i_rd,
  output logic [WIDTH-1:0]        o_rd_data,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [clog2(DEPTH):0]   o_level
);

  localparam int c_ptr_w = clog2(DEPTH);
  localparam int c_lvl_w = clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_level;
  logic               w_do_wr;
  logic               w_do_rd;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == c_lvl_w'(DEPTH));
  assign o_level = r_level;
  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && !o_empty;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_wr && !w_do_rd)      r_level <= r_level + 1'b1;
      else if (!w_do_wr && w_do_rd) r_level <= r_level - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_map_gen.sv
// ============================================================================
// Module      : pixel_map_gen
// Description : Raster-order source-address generator with flip/zoom/blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_map_gen
  import pixel_map_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 800,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int ADDR_WIDTH     = 19,
  parameter int FIFO_DEPTH     = 16,
  parameter int ROW_INIT       = 0,
  parameter int COL_INIT       = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        iREAD,
  input  logic [2:0]                  iMODE,
  input  logic                        iBLANK,
  output logic [ADDR_WIDTH:0]         oADDRESS,
  output logic                        oREADY_N,
  output logic                        oFULL,
  output logic [clog2(FIFO_DEPTH):0]  oLEVEL,
  output logic                        oFRAME_SYNC
);

  localparam int c_row_w = (clog2(DISPLAY_HEIGHT) < 1) ? 1 : clog2(DISPLAY_HEIGHT);
  localparam int c_col_w = (clog2(DISPLAY_WIDTH) < 1) ? 1 : clog2(DISPLAY_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_w_a      = ADDR_WIDTH'(DISPLAY_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_w_last_a = ADDR_WIDTH'(DISPLAY_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_h_last_a = ADDR_WIDTH'(DISPLAY_HEIGHT - 1);

  logic [c_row_w-1:0]    r_row;
  logic [c_col_w-1:0]    r_col;
  logic [2:0]            r_mode;
  logic                  r_blank;
  logic                  r_frame_sync;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_row_last;
  logic                  w_col_last;
  logic                  w_frame_end;
  logic [ADDR_WIDTH-1:0] w_r1;
  logic [ADDR_WIDTH-1:0] w_c1;
  logic [ADDR_WIDTH-1:0] w_r2;
  logic [ADDR_WIDTH-1:0] w_c2;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH:0]   w_word;
  logic                  w_empty;

  assign w_wr        = !w_full;
  assign w_row_last  = (r_row == c_row_w'(DISPLAY_HEIGHT - 1));
  assign w_col_last  = (r_col == c_col_w'(DISPLAY_WIDTH - 1));
  assign w_frame_end = w_wr && w_row_last && w_col_last;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_row <= c_row_w'(ROW_INIT);
      r_col <= c_col_w'(COL_INIT);
    end else if (w_wr) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Mode and blank only change on the last write of a frame, so frames never tear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mode       <= MODE_RESET;
      r_blank      <= 1'b0;
      r_frame_sync <= 1'b0;
    end else begin
      r_frame_sync <= w_frame_end;
      if (w_frame_end) begin
        r_mode  <= iMODE;
        r_blank <= iBLANK;
      end
    end
  end

  always_comb begin
    w_r1   = ADDR_WIDTH'(r_row);
    w_c1   = ADDR_WIDTH'(r_col);
    if (r_mode[MODE_VFLIP]) w_r1 = c_h_last_a - ADDR_WIDTH'(r_row);
    if (r_mode[MODE_HFLIP]) w_c1 = c_w_last_a - ADDR_WIDTH'(r_col);
    w_r2   = r_mode[MODE_ZOOM] ? (w_r1 >> 1) : w_r1;
    w_c2   = r_mode[MODE_ZOOM] ? (w_c1 >> 1) : w_c1;
    w_addr = w_r2 * c_w_a + w_c2;
    w_word = r_blank ? '0 : {1'b1, w_addr};
  end

  pixel_map_sync_fifo #(
    .WIDTH (ADDR_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .i_wr      (w_wr),
    .i_wr_data (w_word),
    .i_rd      (iREAD),
    .o_rd_data (oADDRESS),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_level   (oLEVEL)
  );

  assign oREADY_N    = w_empty;
  assign oFULL       = w_full;
  assign oFRAME_SYNC = r_frame_sync;

endmodule

`default_nettype wire

// File: tb/tb_pixel_map_gen.sv
// ============================================================================
// Module      : tb_pixel_map_gen
// Description : Directed self-checking bench for pixel_map_gen (three configs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_map_gen;

  logic       clk;
  logic       rst_d, rst_s;
  logic       rd_d, rd_a, rd_z;
  logic [2:0] mode_d, mode_a, mode_z;
  logic       blank_d, blank_a, blank_z;

  logic [19:0] addr_d;
  logic        rdyn_d, full_d, fsync_d;
  logic [4:0]  lvl_d;
  logic [4:0]  addr_a, addr_z;
  logic        rdyn_a, full_a, fsync_a, rdyn_z, full_z, fsync_z;
  logic [4:0]  lvl_a, lvl_z;

  int n_cmp = 0;
  int n_err = 0;
  int q_a[$];
  int q_z[$];

  pixel_map_gen u_dut_d (
    .CLK(clk), .RESET(rst_d), .iREAD(rd_d), .iMODE(mode_d), .iBLANK(blank_d),
    .oADDRESS(addr_d), .oREADY_N(rdyn_d), .oFULL(full_d), .oLEVEL(lvl_d),
    .oFRAME_SYNC(fsync_d)
  );

  pixel_map_gen #(.DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(3), .ADDR_WIDTH(4)) u_dut_a (
    .CLK(clk), .RESET(rst_s), .iREAD(rd_a), .iMODE(mode_a), .iBLANK(blank_a),
    .oADDRESS(addr_a), .oREADY_N(rdyn_a), .oFULL(full_a), .oLEVEL(lvl_a),
    .oFRAME_SYNC(fsync_a)
  );

  pixel_map_gen #(.DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(4), .ADDR_WIDTH(4)) u_dut_z (
    .CLK(clk), .RESET(rst_s), .iREAD(rd_z), .iMODE(mode_z), .iBLANK(blank_z),
    .oADDRESS(addr_z), .oREADY_N(rdyn_z), .oFULL(full_z), .oLEVEL(lvl_z),
    .oFRAME_SYNC(fsync_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_d = 1'b1; rst_s = 1'b1;
    rd_d = 1'b1; rd_a = 1'b1; rd_z = 1'b1;
    mode_d = 3'b001; mode_a = 3'b000; mode_z = 3'b100;
    blank_d = 1'b0; blank_a = 1'b0; blank_z = 1'b0;

    // Expected words {valid, addr}: 16 marks the valid bit for 4-bit addresses
    foreach (q_a[i]) q_a.delete(i);
    q_a = '{25, 26, 27, 20, 21, 22, 23, 16, 17, 18, 19};
    for (int k = 0; k < 12; k++) q_a.push_back(16 + k);
    for (int k = 0; k < 12; k++) q_a.push_back(16 + 11 - k);
    for (int k = 0; k < 12; k++) q_a.push_back(0);
    for (int k = 0; k < 12; k++) q_a.push_back(16 + k);
    q_z = '{29, 30, 31, 24, 25, 26, 27, 20, 21, 22, 23, 16, 17, 18, 19,
            16, 16, 17, 17, 16, 16, 17, 17, 20, 20, 21, 21, 20, 20, 21, 21};

    repeat (2) @(negedge clk);
    check_value("rst_level",  32'(lvl_d),   32'd0);
    check_value("rst_ready_n", 32'(rdyn_d), 32'd1);
    check_value("rst_full",   32'(full_d),  32'd0);
    check_value("rst_addr",   32'(addr_d),  32'd0);
    check_value("rst_fsync",  32'(fsync_d), 32'd0);
    check_value("rst_a_level", 32'(lvl_a),  32'd0);
    check_value("rst_a_addr", 32'(addr_a),  32'd0);

    // Default config: first cycle reads while empty, which must not underflow
    rst_d = 1'b0;
    @(negedge clk);
    check_value("d_first_level", 32'(lvl_d),  32'd1);
    check_value("d_first_addr",  32'(addr_d), 32'hDD8E1);
    check_value("d_first_rdyn",  32'(rdyn_d), 32'd0);
    rd_d = 1'b0;
    repeat (15) @(negedge clk);
    check_value("d_full_level", 32'(lvl_d),  32'd16);
    check_value("d_full_flag",  32'(full_d), 32'd1);
    check_value("d_full_head",  32'(addr_d), 32'hDD8E1);
    repeat (3) @(negedge clk);
    check_value("d_hold_level", 32'(lvl_d), 32'd16);
    rd_d = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check_value($sformatf("d_drain_%0d", k), 32'(addr_d), 32'h80000 + 32'd383201 + 32'(k));
    end
    check_value("d_drain_level", 32'(lvl_d),  32'd15);
    check_value("d_drain_fsync", 32'(fsync_d), 32'd0);

    // Small configs: continuous read, head after each edge is the word just written
    rst_s = 1'b0;
    for (int i = 0; i < 59; i++) begin
      @(negedge clk);
      check_value($sformatf("a_word_%0d", i), 32'(addr_a), 32'(q_a[i]));
      check_value($sformatf("a_fsync_%0d", i), 32'(fsync_a),
                  (i == 10 || i == 22 || i == 34 || i == 46 || i == 58) ? 32'd1 : 32'd0);
      if (i < 31) begin
        check_value($sformatf("z_word_%0d", i), 32'(addr_z), 32'(q_z[i]));
        check_value($sformatf("z_fsync_%0d", i), 32'(fsync_z),
                    (i == 14 || i == 30) ? 32'd1 : 32'd0);
      end
      if (i == 15) mode_a = 3'b011;
      if (i == 26) begin
        mode_a  = 3'b000;
        blank_a = 1'b1;
      end
      if (i == 40) blank_a = 1'b0;
    end
    check_value("a_level_steady", 32'(lvl_a), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
